uart_rx_drain: RTL
==================

// Module: uart_rx_drain
// PURPOSE
//  Sits directly downstream of the CoreUART receive side and drains it. Polls RXRDY, issues a CSN/OEN read
//  strobe, then captures DATA_OUT together with the PARITY_ERR, FRAMING_ERR and OVERFLOW status.
//  Each byte is buffered with its error tag in a local FIFO. Bytes leave on a valid/ready stream for
//  downstream packet logic, so the UART holding register or FIFO is emptied without processor involvement.
// PARAMETERS
//  DEPTH      16  local FIFO entries; power of 2, range 4..256
//  WAIT_MAX   8   cycles allowed for RXRDY to fall after a read strobe before a stuck-ready error
// PORTS
//  CLK              in   1  single clock, shared with CoreUART
//  RESET            in   1  synchronous, active-high reset
//  UART_RXRDY       in   1  receive-data-ready from CoreUART
//  UART_DATA_OUT    in   8  received byte from CoreUART
//  UART_PARITY_ERR  in   1  parity status from CoreUART
//  UART_FRAMING_ERR in   1  framing status from CoreUART
//  UART_OVERFLOW    in   1  overflow status from CoreUART
//  UART_CSN         out  1  chip select to CoreUART, active low
//  UART_OEN         out  1  read enable to CoreUART, active low
//  M_VALID          out  1  output byte valid
//  M_READY          in   1  downstream accepts the byte
//  M_DATA           out  8  output byte
//  M_ERR            out  3  error tag: {overflow, framing, parity}
//  STUCK            out  1  sticky; RXRDY failed to clear within WAIT_MAX cycles
//  LEVEL            out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset values: UART_CSN=1, UART_OEN=1, M_VALID=0, M_DATA=0, M_ERR=0, STUCK=0, LEVEL=0, FSM=IDLE.
//  FSM, one transition per clock:
//   IDLE  -> READ when UART_RXRDY=1 and FIFO not full. If the FIFO is full, stay in IDLE and do not read;
//            CoreUART is left to flag overflow.
//   READ  -> CAPT. UART_CSN=0 and UART_OEN=0 for exactly this one cycle; strobes are registered outputs.
//   CAPT  -> WAIT. Sample UART_DATA_OUT and the three error inputs, and push {err,data} into the FIFO.
//   WAIT  -> IDLE when UART_RXRDY=0. If WAIT_MAX cycles pass with RXRDY still 1, set STUCK and go to IDLE.
//  Throughput: at most one byte every 4 cycles; latency is RXRDY rise to M_VALID=1 in 3 cycles (empty FIFO).
//  Output: first-word-fall-through. M_DATA and M_ERR stay stable while M_VALID=1 and M_READY=0.
//   The pop happens on the M_VALID & M_READY edge.
//  A push in CAPT and a pop in the same cycle are both honoured; LEVEL is unchanged.
//  The full check happens only at IDLE->READ, so CAPT never pushes into a full FIFO.
//  Pointers are $clog2(DEPTH) bits and wrap naturally. LEVEL = wr_cnt - rd_cnt, computed one bit wider.
//  RESET mid-operation: if RESET is asserted during READ, UART_CSN/UART_OEN return to 1 on that same
//   edge. The FIFO empties, and any partially captured byte is discarded.
//  STUCK clears only on RESET.
// CONFIGURATION
//  `UART_RX_DRAIN_ERR_CNT_EN defined: adds outputs PAR_CNT, FRM_CNT and OVF_CNT, each 16 bits.
//   Each counter increments on a CAPT cycle whose matching error bit is 1, and saturates at 16'hFFFF.
//   Input CNT_CLR (1 bit) zeroes all three counters; CNT_CLR wins over a simultaneous increment.
//  Macro undefined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package uart_rx_drain_pkg holds:
//   - state enum {IDLE, READ, CAPT, WAIT}
//   - ERR_PAR=0, ERR_FRM=1, ERR_OVF=2 bit indices
//   - the ERR_W=3 constant
//  Sub-module uart_rx_drain_fifo: synchronous FWFT FIFO of width 11 (ERR_W+8), DEPTH deep.
//   It provides full, empty and level outputs. The FSM and counters live in the top.
// TESTING
//  1. Single byte: RXRDY=1 for 0x5A, clean status, M_READY=1 -> exactly one CSN/OEN low pulse;
//     M_VALID 3 cycles later with M_DATA=0x5A, M_ERR=3'b000.
//  2. Parity error: byte 0xC3 with PARITY_ERR=1 -> M_ERR=3'b001. With the macro defined, PAR_CNT=1
//     and FRM_CNT=OVF_CNT=0.
//  3. Backpressure: M_READY=0 while 16 bytes 0x00..0x0F arrive (DEPTH=16) -> LEVEL=16 and no 17th read
//     strobe. After M_READY=1, the bytes drain in order 0x00..0x0F.
//  4. Stuck ready: RXRDY held 1 after the read -> STUCK=1 WAIT_MAX cycles after CAPT. The next strobe
//     follows from IDLE.
//  5. Reset mid-read: assert RESET in the READ cycle -> CSN=OEN=1 after that edge, LEVEL=0, M_VALID=0.
//  6. Counter saturation (macro defined): force PAR_CNT to 16'hFFFF, then a parity-error byte -> the
//     count stays 16'hFFFF. CNT_CLR pulse -> all counters 0.

Source files
------------

// File: rtl/uart_rx_drain_pkg.sv
// Shared types and constants for the CoreUART receive drain block.
package uart_rx_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    WAIT = 2'd3
  } state_e;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OVF = 2;
  localparam int ERR_W   = 3;
  localparam int BYTE_W  = 8;
  localparam int FIFO_W  = ERR_W + BYTE_W;

endpackage

// File: rtl/uart_rx_drain_if.sv
// Valid/ready byte stream carrying a received byte and its {overflow, framing, parity} tag.
interface uart_rx_drain_if;
  import uart_rx_drain_pkg::*;

  logic              M_VALID;
  logic              M_READY;
  logic [BYTE_W-1:0] M_DATA;
  logic [ERR_W-1:0]  M_ERR;

  modport master (output M_VALID, output M_DATA, output M_ERR, input M_READY);
  modport slave  (input M_VALID, input M_DATA, input M_ERR, output M_READY);

endinterface

// File: rtl/uart_rx_drain_fifo.sv
// First-word-fall-through FIFO holding {err, data} entries; read data is zero while empty.
module uart_rx_drain_fifo
  import uart_rx_drain_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = FIFO_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] level;
  logic             push_ok;
  logic             pop_ok;

  // Counters are one bit wider than the pointers so full and empty are distinguishable.
  assign level   = wr_cnt_q - rd_cnt_q;
  assign full_o  = (level == CNT_W'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (push_ok) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    if (pop_ok)  rd_cnt_d = rd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_cnt_q[PTR_W-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_cnt_q[PTR_W-1:0]];

endmodule

// File: rtl/uart_rx_drain.sv
// Drains CoreUART receive data into a local FIFO and presents it on a valid/ready stream.
// Define UART_RX_DRAIN_ERR_CNT_EN to add saturating parity/framing/overflow counters.
module uart_rx_drain
  import uart_rx_drain_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   UART_RXRDY,
  input  logic [BYTE_W-1:0]      UART_DATA_OUT,
  input  logic                   UART_PARITY_ERR,
  input  logic                   UART_FRAMING_ERR,
  input  logic                   UART_OVERFLOW,
  output logic                   UART_CSN,
  output logic                   UART_OEN,
  uart_rx_drain_if.master        m_if,
  output logic                   STUCK,
  output logic [$clog2(DEPTH):0] LEVEL
`ifdef UART_RX_DRAIN_ERR_CNT_EN
  ,
  input  logic                   CNT_CLR,
  output logic [15:0]            PAR_CNT,
  output logic [15:0]            FRM_CNT,
  output logic [15:0]            OVF_CNT
`endif
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_READ = 2'(READ);
  localparam logic [1:0] S_CAPT = 2'(CAPT);
  localparam logic [1:0] S_WAIT = 2'(WAIT);
  localparam int         WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              stuck_q, stuck_d;
  logic              strb_n_q;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ERR_W-1:0]  err_in;
  logic [FIFO_W-1:0] fifo_rdata;

  always_comb begin
    err_in          = '0;
    err_in[ERR_PAR] = UART_PARITY_ERR;
    err_in[ERR_FRM] = UART_FRAMING_ERR;
    err_in[ERR_OVF] = UART_OVERFLOW;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stuck_d = stuck_q;
    push    = 1'b0;
    case (state_q)
      // A full FIFO leaves the byte in CoreUART, which then reports its own overflow.
      S_IDLE: if (UART_RXRDY && !fifo_full) state_d = S_READ;
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        push    = 1'b1;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!UART_RXRDY) begin
          state_d = S_IDLE;
        end else if (wait_q == WCNT_W'(WAIT_MAX - 1)) begin
          stuck_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered so they are low for exactly the READ cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      stuck_q  <= 1'b0;
      strb_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      stuck_q  <= stuck_d;
      strb_n_q <= (state_d != S_READ);
    end
  end

  assign UART_CSN = strb_n_q;
  assign UART_OEN = strb_n_q;
  assign STUCK    = stuck_q;

  assign pop = m_if.M_VALID & m_if.M_READY;

  uart_rx_drain_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .wdata_i ({err_in, UART_DATA_OUT}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (LEVEL)
  );

  assign m_if.M_VALID = ~fifo_empty;
  assign m_if.M_DATA  = fifo_rdata[BYTE_W-1:0];
  assign m_if.M_ERR   = fifo_rdata[FIFO_W-1:BYTE_W];

`ifdef UART_RX_DRAIN_ERR_CNT_EN
  logic [15:0] par_cnt_q;
  logic [15:0] frm_cnt_q;
  logic [15:0] ovf_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Clear takes priority over an increment landing on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET || CNT_CLR) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (push) begin
      if (err_in[ERR_PAR]) par_cnt_q <= sat_inc16(par_cnt_q);
      if (err_in[ERR_FRM]) frm_cnt_q <= sat_inc16(frm_cnt_q);
      if (err_in[ERR_OVF]) ovf_cnt_q <= sat_inc16(ovf_cnt_q);
    end
  end

  assign PAR_CNT = par_cnt_q;
  assign FRM_CNT = frm_cnt_q;
  assign OVF_CNT = ovf_cnt_q;
`endif

endmodule
